// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: receives framed serial ALU requests (8 DATA frames carrying
// operands A and B, then one CMD frame carrying opcode and CRC-4) and presents either
// a validated request or a one-hot error code.
// Optional feature: define MTM_ALU_DESER_TIMEOUT_EN to abandon a partial packet after
// TIMEOUT_CYCLES idle cycles.
module mtm_alu_deserializer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic [31:0] data_a,
    output logic [31:0] data_b,
    output logic [2:0]  opcode,
    output logic        req_valid,
    output logic [2:0]  err_code,
    output logic        err_valid
);

    typedef enum logic [1:0] {StIdle, StType, StPayload, StStop} state_e;

    localparam logic [2:0] ErrData = 3'b100;
    localparam logic [2:0] ErrCrc  = 3'b010;
    localparam logic [2:0] ErrOp   = 3'b001;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        type_q, type_d;
    logic        armed_q, armed_d;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic [63:0] buf_q, buf_d;
    logic        ferr_q, ferr_d;
    logic [31:0] data_a_q, data_a_d;
    logic [31:0] data_b_q, data_b_d;
    logic [2:0]  opcode_q, opcode_d;
    logic [2:0]  err_code_q, err_code_d;
    logic        req_valid_q, req_valid_d;
    logic        err_valid_q, err_valid_d;

    logic [2:0]  cmd_op;
    logic [3:0]  cmd_crc;
    logic [3:0]  crc_calc;
    logic [5:0]  wr_lsb;
    logic        start_seen;

`ifdef MTM_ALU_DESER_TIMEOUT_EN
    logic [31:0] timer_q, timer_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Serial CRC-4 (x^4+x+1, init 0), MSB of the message shifted in first.
    function automatic logic [3:0] crc4(input logic [67:0] msg);
        logic [3:0] c;
        logic       fb;
        c = '0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2:1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    assign cmd_op     = shift_q[6:4];
    assign cmd_crc    = shift_q[3:0];
    assign crc_calc   = crc4({buf_q, 1'b1, cmd_op});
    assign wr_lsb     = {~frame_cnt_q[2:0], 3'b000};
    // A start bit only counts once the line has been seen idle since reset.
    assign start_seen = (state_q == StIdle) && armed_q && !sin;

    // State register and all datapath flops, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            type_q      <= 1'b0;
            armed_q     <= 1'b0;
            frame_cnt_q <= '0;
            buf_q       <= '0;
            ferr_q      <= 1'b0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            opcode_q    <= '0;
            err_code_q  <= '0;
            req_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
`ifdef MTM_ALU_DESER_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            type_q      <= type_d;
            armed_q     <= armed_d;
            frame_cnt_q <= frame_cnt_d;
            buf_q       <= buf_d;
            ferr_q      <= ferr_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            opcode_q    <= opcode_d;
            err_code_q  <= err_code_d;
            req_valid_q <= req_valid_d;
            err_valid_q <= err_valid_d;
`ifdef MTM_ALU_DESER_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    // Frame FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start_seen) state_d = StType;
            StType:    state_d = StPayload;
            StPayload: if (bit_cnt_q == 3'd7) state_d = StStop;
            StStop:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Bit capture, packet buffering, CMD checking and output register updates.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        type_d      = type_q;
        armed_d     = armed_q | sin;
        frame_cnt_d = frame_cnt_q;
        buf_d       = buf_q;
        ferr_d      = ferr_q;
        data_a_d    = data_a_q;
        data_b_d    = data_b_q;
        opcode_d    = opcode_q;
        err_code_d  = err_code_q;
        req_valid_d = 1'b0;
        err_valid_d = 1'b0;
`ifdef MTM_ALU_DESER_TIMEOUT_EN
        timer_d     = '0;
`endif

        unique case (state_q)
            StIdle: begin
`ifdef MTM_ALU_DESER_TIMEOUT_EN
                if (!start_seen && frame_cnt_q != 4'd0) begin
                    if (timer_q == TIMEOUT_CYCLES - 1) begin
                        frame_cnt_d = '0;
                        buf_d       = '0;
                        ferr_d      = 1'b0;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
`endif
            end
            StType: begin
                type_d    = sin;
                bit_cnt_d = '0;
            end
            StPayload: begin
                shift_d   = {shift_q[6:0], sin};
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            StStop: begin
                if (!sin) begin
                    // Broken frame: drop it, but remember so the packet fails at its CMD.
                    ferr_d = 1'b1;
                end else if (!type_q) begin
                    if (frame_cnt_q < 4'd8) buf_d[wr_lsb +: 8] = shift_q;
                    if (frame_cnt_q != 4'd9) frame_cnt_d = frame_cnt_q + 4'd1;
                end else begin
                    if (frame_cnt_q != 4'd8 || ferr_q) begin
                        err_code_d  = ErrData;
                        err_valid_d = 1'b1;
                    end else if (crc_calc != cmd_crc) begin
                        err_code_d  = ErrCrc;
                        err_valid_d = 1'b1;
                    end else if (!(cmd_op inside {3'b000, 3'b001, 3'b100, 3'b101})) begin
                        err_code_d  = ErrOp;
                        err_valid_d = 1'b1;
                    end else begin
                        data_a_d    = buf_q[63:32];
                        data_b_d    = buf_q[31:0];
                        opcode_d    = cmd_op;
                        req_valid_d = 1'b1;
                    end
                    frame_cnt_d = '0;
                    buf_d       = '0;
                    ferr_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign data_a    = data_a_q;
    assign data_b    = data_b_q;
    assign opcode    = opcode_q;
    assign err_code  = err_code_q;
    assign req_valid = req_valid_q;
    assign err_valid = err_valid_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer: directed and randomized packets against a frame-level
// reference model (byte queue plus sticky error flag). Outputs are compared at every
// negedge. Timeout scenario is compiled in when MTM_ALU_DESER_TIMEOUT_EN is defined.
module tb_mtm_alu_deserializer;

    localparam int unsigned TimeoutCycles = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin = 1'b1;
    logic [31:0] data_a, data_b;
    logic [2:0]  opcode, err_code;
    logic        req_valid, err_valid;

    mtm_alu_deserializer #(
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .data_a    (data_a),
        .data_b    (data_b),
        .opcode    (opcode),
        .req_valid (req_valid),
        .err_code  (err_code),
        .err_valid (err_valid)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Expected output state
    logic [31:0] exp_a = '0, exp_b = '0;
    logic [2:0]  exp_op = '0, exp_code = '0;
    logic        exp_req = 1'b0, exp_err = 1'b0;

    // Reference model of the packet in progress
    logic [7:0] m_bytes[$];
    int         m_cnt = 0;
    logic       m_ferr = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Remainder of {msg, 0000} divided by x^4+x+1.
    function automatic logic [3:0] ref_crc(input logic [67:0] msg);
        logic [71:0] r;
        r = {msg, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    task automatic model_clear();
        m_bytes.delete();
        m_cnt  = 0;
        m_ferr = 1'b0;
    endtask

    task automatic check_outputs();
        check_val("req_valid", 32'(req_valid), 32'(exp_req));
        check_val("err_valid", 32'(err_valid), 32'(exp_err));
        check_val("data_a", data_a, exp_a);
        check_val("data_b", data_b, exp_b);
        check_val("opcode", 32'(opcode), 32'(exp_op));
        check_val("err_code", 32'(err_code), 32'(exp_code));
        exp_req = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic tick(input logic b);
        @(negedge clk);
        check_outputs();
        sin = b;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1);
`ifdef MTM_ALU_DESER_TIMEOUT_EN
        if (n > int'(TimeoutCycles) + 1 && m_cnt > 0) model_clear();
`endif
    endtask

    task automatic do_reset(input int cycles, input logic s);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_outputs();
            rst_n = 1'b0;
            sin = s;
            exp_a = '0; exp_b = '0; exp_op = '0; exp_code = '0;
        end
        model_clear();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        sin = s;
    endtask

    // Model reaction to one complete frame.
    task automatic model_frame(input logic is_cmd, input logic [7:0] p, input logic stop_ok);
        logic [31:0] a, b;
        logic [2:0]  op;
        if (!stop_ok) begin
            m_ferr = 1'b1;
        end else if (!is_cmd) begin
            if (m_bytes.size() < 8) m_bytes.push_back(p);
            if (m_cnt < 9) m_cnt++;
        end else begin
            op = p[6:4];
            if (m_cnt != 8 || m_ferr) begin
                exp_err = 1'b1; exp_code = 3'b100;
            end else begin
                a = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                b = {m_bytes[4], m_bytes[5], m_bytes[6], m_bytes[7]};
                if (ref_crc({a, b, 1'b1, op}) != p[3:0]) begin
                    exp_err = 1'b1; exp_code = 3'b010;
                end else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) begin
                    exp_err = 1'b1; exp_code = 3'b001;
                end else begin
                    exp_req = 1'b1; exp_a = a; exp_b = b; exp_op = op;
                end
            end
            model_clear();
        end
    endtask

    task automatic send_frame(input logic is_cmd, input logic [7:0] p, input logic stop_bit,
                              input int gap);
        tick(1'b0);
        tick(is_cmd);
        for (int i = 7; i >= 0; i--) tick(p[i]);
        tick(stop_bit);
        model_frame(is_cmd, p, stop_bit);
        idle(gap);
    endtask

    task automatic send_packet(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                               input logic [3:0] crc_xor, input int n_data, input int bad_stop,
                               input int gap);
        logic [63:0] ab;
        logic [7:0]  byte_v;
        ab = {a, b};
        for (int i = 0; i < n_data; i++) begin
            if (i < 8) byte_v = ab[63 - 8*i -: 8];
            else byte_v = 8'($urandom);
            send_frame(1'b0, byte_v, (i == bad_stop) ? 1'b0 : 1'b1, gap);
        end
        send_frame(1'b1, {1'b1, op, ref_crc({a, b, 1'b1, op}) ^ crc_xor},
                   (n_data == bad_stop) ? 1'b0 : 1'b1, gap);
    endtask

    initial begin
        do_reset(2, 1'b1);

        // Basic valid request, then the same with a corrupted CRC bit
        send_packet(32'h0000_0001, 32'h0000_0002, 3'b100, 4'b0000, 8, -1, 2);
        send_packet(32'h0000_0001, 32'h0000_0002, 3'b100, 4'b0001, 8, -1, 2);

        // Too few data frames, then a valid back-to-back packet
        send_packet(32'hDEAD_BEEF, 32'h1234_5678, 3'b001, 4'b0000, 7, -1, 0);
        send_packet(32'hCAFE_F00D, 32'h8765_4321, 3'b101, 4'b0000, 8, -1, 0);

        // Invalid opcode, and invalid opcode with bad CRC (CRC wins)
        send_packet(32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b010, 4'b0000, 8, -1, 1);
        send_packet(32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b010, 4'b1000, 8, -1, 1);

        // CMD with no data, too many data frames, then recovery
        send_packet(32'h0, 32'h0, 3'b000, 4'b0000, 0, -1, 1);
        send_packet(32'h1111_2222, 32'h3333_4444, 3'b000, 4'b0000, 9, -1, 1);
        send_packet(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, 4'b0000, 8, -1, 1);

        // Broken stop bit on a data frame; broken stop bit on a CMD (frame dropped)
        send_packet(32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'b100, 4'b0000, 8, 3, 1);
        send_packet(32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'b100, 4'b0000, 8, 8, 1);
        send_packet(32'h0102_0304, 32'h0506_0708, 3'b001, 4'b0000, 8, -1, 1);
        send_packet(32'h0102_0304, 32'h0506_0708, 3'b001, 4'b0000, 8, -1, 1);

        // Reset mid-packet after 4 data frames, then a clean packet
        for (int i = 0; i < 4; i++) send_frame(1'b0, 8'($urandom), 1'b1, 0);
        do_reset(2, 1'b1);
        send_packet(32'h7654_3210, 32'h0BAD_CAFE, 3'b100, 4'b0000, 8, -1, 1);

        // Reset mid-frame
        tick(1'b0); tick(1'b1); tick(1'b1); tick(1'b0);
        do_reset(2, 1'b1);
        send_packet(32'h1357_9BDF, 32'h2468_ACE0, 3'b000, 4'b0000, 8, -1, 1);

        // Line held low through and after reset must not start a frame
        do_reset(2, 1'b0);
        repeat (5) tick(1'b0);
        idle(12);
        send_packet(32'h0000_00FF, 32'hFF00_0000, 3'b101, 4'b0000, 8, -1, 1);

`ifdef MTM_ALU_DESER_TIMEOUT_EN
        // Partial packet abandoned after a long idle gap
        for (int i = 0; i < 3; i++) send_frame(1'b0, 8'($urandom), 1'b1, 0);
        idle(25);
        send_packet(32'h0000_0001, 32'h0000_0002, 3'b100, 4'b0000, 8, -1, 1);
`endif

        // Randomized packets
        for (int k = 0; k < 60; k++) begin
            logic [31:0] ra, rb;
            logic [2:0]  rop;
            logic [3:0]  rx;
            int          nd, bs;
            ra  = $urandom;
            rb  = $urandom;
            rop = 3'($urandom_range(0, 7));
            nd  = ($urandom_range(0, 99) < 70) ? 8 : int'($urandom_range(0, 10));
            rx  = ($urandom_range(0, 99) < 15) ? 4'($urandom_range(1, 15)) : 4'b0000;
            bs  = ($urandom_range(0, 99) < 5) ? int'($urandom_range(0, nd)) : -1;
            send_packet(ra, rb, rop, rx, nd, bs, int'($urandom_range(0, 3)));
        end

        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
